hex_scroller: RTL
=================

Name: hex_scroller

Overview:
- Upstream source for the eight-digit HEX display path. Produces the 32-bit packed character word (8 x 4-bit codes) consumed by the per-digit Decoder instances.
- Holds a 16-entry message memory, writable at run time, and scrolls it across the 8 digits.
- Scrolling is either auto-timed (prescaled system clock) or manual single-step, with selectable direction and run-time message length.

Parameters:
- DIV, 50_000_000, system-clock cycles per auto-scroll step (1 Hz at 50 MHz); legal range >= 2.
- MSG_DEPTH, 16, message memory entries (fixed 4-bit address); not intended to change.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- run  in  1  1 = auto-scroll on prescaler terminal count; 0 = paused.
- dir  in  1  0 = scroll left (offset +1); 1 = scroll right (offset -1).
- step_req  in  1  single-cycle pulse; advances one step only while run=0.
- len  in  5  active message length; clamped to the range 8..16.
- wr_en  in  1  message write strobe.
- wr_addr  in  4  message entry index.
- wr_data  in  4  character code to write.
- Q  out  32  packed display word; Q[31:28] = leftmost digit (HEX7), Q[3:0] = HEX0.
- step  out  1  one-cycle pulse on every offset change.
- wrap  out  1  one-cycle pulse when offset changes to 0.

Behaviour:
- Character codes: H=4'h0, E=4'h1, L=4'h2, O=4'h3, BLANK=4'h7.
- Reset:
  - msg[0..4] = H,E,L,L,O; msg[5..15] = BLANK.
  - offset=0, prescaler=0, step=0, wrap=0.
  - Q = 32'h0122_3777 (reads "HELLO" + 3 blanks).
  - Reset overrides every other input in the same cycle.
- Effective length:
  - L = 8 if len<8; L = 16 if len>16; else L = len.
  - L is re-evaluated every cycle.
- Prescaler:
  - Counts 0..DIV-1 only while run=1; holds its value while run=0.
  - Terminal count (DIV-1) raises an advance and returns the counter to 0.
- Advance sources:
  - run=1: prescaler terminal count only; step_req is ignored.
  - run=0: step_req=1 produces exactly one advance per pulse.
- Offset update on advance:
  - dir=0: offset = (offset==L-1) ? 0 : offset+1.
  - dir=1: offset = (offset==0) ? L-1 : offset-1.
  - step=1 in the cycle after the edge that updates offset.
  - wrap=1 in that same cycle when the new offset is 0.
- Length shrink: if offset >= L in any cycle (len lowered), offset is forced to 0 on the next edge. This raises wrap but not step. It takes priority over an advance in the same cycle.
- Q is registered and recomputed every cycle:
  - digit i (i=7 is leftmost) = msg[(offset_next + (7-i)) mod L].
  - The offset change and the Q update are visible on the same edge: zero latency from advance to display.
- Writes:
  - msg[wr_addr] <= wr_data on the edge where wr_en=1.
  - Q reflects the new character one edge later (1-cycle write-to-display latency).
  - Writes to addresses >= L are stored but not displayed until L grows.
- Simultaneous write and advance: both take effect. Q at that edge uses the old cell content; it corrects on the next edge.
- Changing dir takes effect on the next advance. The prescaler is not reset by changes to dir, len, or wr_en.

Decomposition:
- Shared package hex_pkg holds:
  - character-code localparams (CHAR_H, CHAR_E, CHAR_L, CHAR_O, CHAR_BLANK);
  - LEN_MIN=8 and LEN_MAX=16;
  - the reset message contents.
- One sub-module: tick_prescaler, a parameterised divider with enable that outputs a one-cycle tick. It is reusable by other display stages.
- The offset/Q logic and message memory stay in hex_scroller.

Test Plan:
1. Reset, then run=0, len=16, no stimulus for 100 cycles -> Q holds 32'h0122_3777; step=0 and wrap=0 throughout.
2. DIV=4 (sim override), run=1, dir=0, len=16 -> Q=32'h1223_7777 at cycle 4 after release, then 32'h2237_7777 at cycle 8. After 16 advances, wrap pulses once and Q returns to 32'h0122_3777.
3. run=0, dir=1, len=8, one step_req pulse -> offset 0 goes to 7; Q=32'h7012_2377; step=1 and wrap=0. Then 7 more pulses -> offset returns to 0 and wrap pulses on the last one.
4. run=1 with step_req held high, DIV=4 -> advances occur only every 4 cycles; step_req has no effect.
5. Write wr_addr=7, wr_data=0 at offset 0 -> Q[3:0] reads 4'h7 on the write edge and 4'h0 one edge later. A simultaneous advance on the write edge also resolves correctly one edge later.
6. With offset=12 and len=16, set len=5 -> L clamps to 8; offset forced to 0 on the next edge; wrap=1, step=0. Assert Reset mid-run with DIV=4 -> next edge restores the full reset state and the prescaler restarts from 0.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared constants for the HEX display path: character codes, length limits and
// the power-on message.
package hex_pkg;

    localparam int unsigned MSG_DEPTH = 16;

    localparam logic [3:0] CHAR_H     = 4'h0;
    localparam logic [3:0] CHAR_E     = 4'h1;
    localparam logic [3:0] CHAR_L     = 4'h2;
    localparam logic [3:0] CHAR_O     = 4'h3;
    localparam logic [3:0] CHAR_BLANK = 4'h7;

    localparam logic [4:0] LEN_MIN = 5'd8;
    localparam logic [4:0] LEN_MAX = 5'd16;

    // Entry 0 sits in the low nibble.
    localparam logic [MSG_DEPTH*4-1:0] RESET_MSG =
        {{11{CHAR_BLANK}}, CHAR_O, CHAR_L, CHAR_L, CHAR_E, CHAR_H};

    // Display word for RESET_MSG at offset 0 with an 8-character window.
    localparam logic [31:0] RESET_Q = 32'h0122_3777;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        if (len < LEN_MIN) begin
            return LEN_MIN;
        end else if (len > LEN_MAX) begin
            return LEN_MAX;
        end
        return len;
    endfunction

endpackage

// File: rtl/hex_scroller_if.sv
// Control, message-write and display signals between a scroller and its user.
interface hex_scroller_if;

    logic        run;
    logic        dir;
    logic        step_req;
    logic [4:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [31:0] Q;
    logic        step;
    logic        wrap;

    modport master (
        output run, dir, step_req, len, wr_en, wr_addr, wr_data,
        input  Q, step, wrap
    );

    modport slave (
        input  run, dir, step_req, len, wr_en, wr_addr, wr_data,
        output Q, step, wrap
    );

endinterface

// File: rtl/tick_prescaler.sv
// Enable-gated divider: tick is high for one cycle every DIV enabled cycles.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a 16-entry writable message across eight HEX digits, either on a
// prescaled timer or by single steps, in either direction.
module hex_scroller
    import hex_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic          Clock,
    input  logic          Reset,
    hex_scroller_if.slave bus
);

    logic [3:0]  msg_q [MSG_DEPTH];
    logic [3:0]  offset_q, offset_d;
    logic [31:0] q_q, q_d;
    logic        step_q, step_d;
    logic        wrap_q, wrap_d;
    logic [4:0]  len_eff;
    logic [4:0]  idx;
    logic        tick;
    logic        adv;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (Clock),
        .rst  (Reset),
        .en   (bus.run),
        .tick (tick)
    );

    always_comb begin
        len_eff  = clamp_len(bus.len);
        adv      = bus.run ? tick : bus.step_req;
        offset_d = offset_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        q_d      = '0;
        idx      = '0;

        // A shrunken length snaps the window home and wins over any advance.
        if ({1'b0, offset_q} >= len_eff) begin
            offset_d = '0;
            wrap_d   = 1'b1;
        end else if (adv) begin
            step_d = 1'b1;
            if (!bus.dir) begin
                offset_d = ({1'b0, offset_q} == len_eff - 5'd1) ? 4'd0 : offset_q + 4'd1;
            end else begin
                offset_d = (offset_q == 4'd0) ? 4'(len_eff - 5'd1) : offset_q - 4'd1;
            end
            wrap_d = (offset_d == 4'd0);
        end

        // offset_d < L and 7-i < L, so one conditional subtract is the modulo.
        for (int i = 0; i < 8; i++) begin
            idx = {1'b0, offset_d} + 5'(7 - i);
            if (idx >= len_eff) begin
                idx = idx - len_eff;
            end
            q_d[i*4 +: 4] = msg_q[idx[3:0]];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_q[i] <= RESET_MSG[i*4 +: 4];
            end
            offset_q <= '0;
            q_q      <= RESET_Q;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                msg_q[bus.wr_addr] <= bus.wr_data;
            end
            offset_q <= offset_d;
            q_q      <= q_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule
